self_test_sorter: RTL and testbench

- Parametrised next-generation stack-sort / chip-ID assignment engine for the 3D self-test path.
- Each die either starts the chain (f_layer=1) or waits for a beacon from the die below, then adopts the ID it was given.
- It then beacons the next ID upward, stepping transmit power until the next die answers or maximum power is exhausted.
- New relative to the previous generation:
  - Widths, timeout and power range are parameters.
  - Input frames are qualified by a valid strobe.
  - All state is registered.
  - Top-of-stack is detected and reported.
  - Assigned ID and power level are exported.

---
 rtl/self_test_sorter.sv | 169 ++++++++++++++++
 tb/tb_self_test_sorter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/self_test_sorter.sv
// Stack-sort / chip-ID assignment engine for the 3D self-test path.
// Adopts an ID from the die below, then beacons the next ID upward with stepped TX power.
module self_test_sorter #(
  parameter int unsigned ID_W      = 4,
  parameter int unsigned PWR_W     = 4,
  parameter int unsigned PWR_INIT  = 1,
  parameter int unsigned MAX_PWR   = 15,
  parameter int unsigned TIMEOUT   = 20,
  parameter logic [15:0] SYNC_WORD = 16'hBEEF,
  parameter logic [3:0]  FRM_TYPE  = 4'hA,
  localparam int unsigned DATA_W   = 20 + PWR_W + 2 * ID_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_layer,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_in_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              tx_valid,
  output logic [ID_W-1:0]   chip_id,
  output logic [PWR_W-1:0]  pwr_level,
  output logic              sort_finish,
  output logic              top_layer
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX_WAIT,
    S_TX,
    S_RX_ACK,
    S_STANDBY
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [ID_W-1:0]     r_chip_id;
  logic [PWR_W-1:0]    r_pwr;
  logic                r_top;
  logic                r_tx_valid;
  logic                r_finish;
  logic [DATA_W-1:0]   r_data_out;

  state_t              w_state_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [ID_W-1:0]     w_chip_id_nxt;
  logic [PWR_W-1:0]    w_pwr_nxt;
  logic                w_top_nxt;
  logic                w_tx_valid_nxt;
  logic                w_finish_nxt;
  logic [DATA_W-1:0]   w_data_out_nxt;
  logic [ID_W-1:0]     w_dst_id_nxt;

  // Received frame fields
  logic [3:0]          w_rx_type;
  logic [PWR_W-1:0]    w_rx_pwr;
  logic [ID_W-1:0]     w_rx_src;
  logic [ID_W-1:0]     w_rx_dst;
  logic [15:0]         w_rx_sync;
  logic                w_beacon;
  logic                w_ack;
  logic [ID_W-1:0]     w_next_id;
  logic                w_unused_pwr;

  assign w_rx_type    = data_in[DATA_W-1 -: 4];
  assign w_rx_pwr     = data_in[DATA_W-5 -: PWR_W];
  assign w_rx_src     = data_in[16+2*ID_W-1 -: ID_W];
  assign w_rx_dst     = data_in[16+ID_W-1 -: ID_W];
  assign w_rx_sync    = data_in[15:0];
  assign w_unused_pwr = ^w_rx_pwr;

  assign w_beacon  = data_in_valid && (w_rx_sync == SYNC_WORD) && (w_rx_type == FRM_TYPE);
  assign w_next_id = r_chip_id + ID_W'(1);
  assign w_ack     = w_beacon && (w_rx_src == w_next_id);

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_chip_id  <= '0;
      r_pwr      <= PWR_W'(PWR_INIT);
      r_top      <= 1'b0;
      r_tx_valid <= 1'b0;
      r_finish   <= 1'b0;
      r_data_out <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_chip_id  <= w_chip_id_nxt;
      r_pwr      <= w_pwr_nxt;
      r_top      <= w_top_nxt;
      r_tx_valid <= w_tx_valid_nxt;
      r_finish   <= w_finish_nxt;
      r_data_out <= w_data_out_nxt;
    end
  end

  // Next-state logic; the beacon frame is built from next-cycle values so it is registered
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_chip_id_nxt = r_chip_id;
    w_pwr_nxt     = r_pwr;
    w_top_nxt     = r_top;

    case (r_state)
      S_IDLE: begin
        if (f_layer) begin
          w_chip_id_nxt = ID_W'(1);
          w_state_nxt   = S_TX;
        end else begin
          w_state_nxt   = S_RX_WAIT;
        end
      end
      S_RX_WAIT: begin
        if (w_beacon && (w_rx_dst != '0)) begin
          w_chip_id_nxt = w_rx_dst;
          if (w_rx_dst == '1) begin
            w_state_nxt = S_STANDBY;
            w_top_nxt   = 1'b1;
          end else begin
            w_state_nxt = S_TX;
          end
        end
      end
      S_TX: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_RX_ACK;
      end
      S_RX_ACK: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (w_ack) begin
          w_state_nxt = S_STANDBY;
          w_top_nxt   = 1'b0;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          if (r_pwr == PWR_W'(MAX_PWR)) begin
            w_state_nxt = S_STANDBY;
            w_top_nxt   = 1'b1;
          end else begin
            w_pwr_nxt   = r_pwr + PWR_W'(1);
            w_state_nxt = S_TX;
          end
        end
      end
      S_STANDBY: begin
        w_state_nxt = S_STANDBY;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_dst_id_nxt   = w_chip_id_nxt + ID_W'(1);
    w_tx_valid_nxt = (w_state_nxt == S_TX);
    w_finish_nxt   = (w_state_nxt == S_STANDBY);
    w_data_out_nxt = w_tx_valid_nxt ?
                     {FRM_TYPE, w_pwr_nxt, w_chip_id_nxt, w_dst_id_nxt, SYNC_WORD} : '0;
  end

  assign data_out    = r_data_out;
  assign tx_valid    = r_tx_valid;
  assign chip_id     = r_chip_id;
  assign pwr_level   = r_pwr;
  assign sort_finish = r_finish;
  assign top_layer   = r_top;

endmodule

// File: tb/tb_self_test_sorter.sv
// Bench for self_test_sorter: directed scenarios plus random frames, checked every
// cycle against a behavioural model tracking phase and cycles since the last beacon.
module tb_self_test_sorter;

  localparam int unsigned TIMEOUT  = 20;
  localparam int unsigned PWR_INIT = 1;
  localparam int unsigned MAX_PWR  = 15;

  logic        clk;
  logic        rst;
  logic        f_layer;
  logic [31:0] data_in;
  logic        data_in_valid;
  logic [31:0] data_out;
  logic        tx_valid;
  logic [3:0]  chip_id;
  logic [3:0]  pwr_level;
  logic        sort_finish;
  logic        top_layer;

  self_test_sorter dut (
    .clk           (clk),
    .rst           (rst),
    .f_layer       (f_layer),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .data_out      (data_out),
    .tx_valid      (tx_valid),
    .chip_id       (chip_id),
    .pwr_level     (pwr_level),
    .sort_finish   (sort_finish),
    .top_layer     (top_layer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;
  int n_tx   = 0;
  int cyc_no = 0;
  int t_prev = 0;
  int t_last = 0;

  // Model: phase 0 fresh, 1 waiting for ID, 2 beaconing, 3 done
  int m_phase = 0;
  int m_age   = 0;
  int m_id    = 0;
  int m_pwr   = PWR_INIT;
  bit m_top   = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc_no);
    end
  endtask

  function automatic logic [31:0] frm(input int t, input int p, input int s, input int d,
                                      input int sy);
    return 32'((t % 16) * (1 << 28) + (p % 16) * (1 << 24) + (s % 16) * (1 << 20)
               + (d % 16) * (1 << 16) + (sy % 65536));
  endfunction

  task automatic model_step();
    int  src;
    int  dst;
    bit  bcn;
    src = int'((data_in >> 20) & 32'hF);
    dst = int'((data_in >> 16) & 32'hF);
    bcn = data_in_valid && (data_in[15:0] == 16'hBEEF) && (data_in[31:28] == 4'hA);
    if (rst) begin
      m_phase = 0; m_age = 0; m_id = 0; m_pwr = PWR_INIT; m_top = 1'b0;
    end else begin
      case (m_phase)
        0: begin
          if (f_layer) begin m_id = 1; m_phase = 2; m_age = 0; end
          else m_phase = 1;
        end
        1: begin
          if (bcn && dst != 0) begin
            m_id = dst;
            if (dst == 15) begin m_phase = 3; m_top = 1'b1; end
            else begin m_phase = 2; m_age = 0; end
          end
        end
        2: begin
          if (m_age >= 1 && bcn && src == (m_id + 1) % 16) begin
            m_phase = 3; m_top = 1'b0;
          end else if (m_age == TIMEOUT) begin
            if (m_pwr == MAX_PWR) begin m_phase = 3; m_top = 1'b1; end
            else begin m_pwr++; m_age = 0; end
          end else begin
            m_age++;
          end
        end
        default: ;
      endcase
    end
  endtask

  function automatic logic [42:0] model_outs();
    bit          tx;
    logic [31:0] f;
    tx = (m_phase == 2) && (m_age == 0);
    f  = tx ? frm(10, m_pwr, m_id, m_id + 1, 16'hBEEF) : 32'h0;
    return {f, tx, 4'(m_id), 4'(m_pwr), (m_phase == 3), m_top};
  endfunction

  // One clock: apply inputs, advance model at the edge, compare at the falling edge
  task automatic cyc(input logic r, input logic fl, input logic [31:0] d, input logic v);
    rst = r; f_layer = fl; data_in = d; data_in_valid = v;
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc_no++;
    chk("outputs", 64'({data_out, tx_valid, chip_id, pwr_level, sort_finish, top_layer}),
        64'(model_outs()));
    if (tx_valid) begin
      n_tx++;
      t_prev = t_last;
      t_last = cyc_no;
    end
  endtask

  initial begin
    int ack_pct;
    int k;
    logic fl;
    logic [31:0] d;
    logic v;
    logic r;
    int done_cnt;

    rst = 1'b1; f_layer = 1'b0; data_in = '0; data_in_valid = 1'b0;

    // Reset state
    cyc(1, 0, 0, 0);
    chk("rst_pwr", 64'(pwr_level), 64'd1);
    chk("rst_id", 64'(chip_id), 64'd0);
    chk("rst_flags", 64'({tx_valid, sort_finish, top_layer}), 64'd0);

    // Bottom die, no acks: full power sweep
    cyc(1, 0, 0, 0);
    n_tx = 0;
    for (int i = 0; i < 400 && !sort_finish; i++) begin
      cyc(0, 1, 0, 0);
      if (tx_valid) begin
        chk("sweep_data", 64'(data_out), 64'(32'hA012BEEF + (32'(n_tx) << 24)));
        if (n_tx > 1) chk("sweep_gap", 64'(t_last - t_prev), 64'd21);
      end
    end
    chk("sweep_count", 64'(n_tx), 64'd15);
    chk("sweep_end", 64'({sort_finish, top_layer, pwr_level}), 64'({1'b1, 1'b1, 4'd15}));

    // Bottom die, ack on the third cycle after the second beacon
    cyc(1, 0, 0, 0);
    n_tx = 0;
    for (int i = 0; i < 100 && n_tx < 2; i++) cyc(0, 1, 0, 0);
    chk("ack2_beacons", 64'(n_tx), 64'd2);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0);
    cyc(0, 1, 32'hA123BEEF, 1);
    chk("ack2_end", 64'({sort_finish, top_layer, chip_id, pwr_level}),
        64'({1'b1, 1'b0, 4'd1, 4'd2}));
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0);
    chk("ack2_no_more", 64'(n_tx), 64'd2);

    // Middle die
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 32'hA312BEEF, 1);
    chk("mid_id", 64'(chip_id), 64'd2);
    chk("mid_beacon", 64'({tx_valid, data_out}), 64'({1'b1, 32'hA123BEEF}));
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 32'hA134BEEF, 1);
    chk("mid_end", 64'({sort_finish, top_layer}), 64'({1'b1, 1'b0}));

    // Filtering: three ignored frames, then an ack exactly on the last window cycle
    cyc(1, 0, 0, 0);
    n_tx = 0;
    cyc(0, 1, 0, 0);
    chk("filt_first", 64'(n_tx), 64'd1);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 32'hA123BEEF, 0);
    cyc(0, 1, 32'hA123DEAD, 1);
    cyc(0, 1, 32'hA112BEEF, 1);
    for (int i = 0; i < TIMEOUT - 4; i++) cyc(0, 1, 0, 0);
    chk("filt_pending", 64'(sort_finish), 64'd0);
    cyc(0, 1, 32'hA123BEEF, 1);
    chk("filt_end", 64'({sort_finish, top_layer, pwr_level}), 64'({1'b1, 1'b0, 4'd1}));
    chk("filt_count", 64'(n_tx), 64'd1);

    // ID exhaustion
    cyc(1, 0, 0, 0);
    n_tx = 0;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 32'hA3EFBEEF, 1);
    chk("exh_end", 64'({chip_id, sort_finish, top_layer}), 64'({4'd15, 1'b1, 1'b1}));
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
    chk("exh_no_tx", 64'(n_tx), 64'd0);

    // Reset during the third attempt
    cyc(1, 0, 0, 0);
    n_tx = 0;
    for (int i = 0; i < 200 && n_tx < 3; i++) cyc(0, 1, 0, 0);
    chk("rmid_reach", 64'(n_tx), 64'd3);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 0);
    chk("rmid_reset", 64'({data_out, tx_valid, chip_id, pwr_level, sort_finish, top_layer}),
        64'({32'h0, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0}));
    cyc(0, 1, 0, 0);
    chk("rmid_restart", 64'({tx_valid, data_out}), 64'({1'b1, 32'hA112BEEF}));

    // Random episodes
    for (int ep = 0; ep < 30; ep++) begin
      cyc(1, 0, 0, 0);
      fl       = 1'($urandom_range(0, 1));
      ack_pct  = $urandom_range(0, 8);
      done_cnt = 0;
      for (int n = 0; n < 400 && done_cnt < 6; n++) begin
        k = $urandom_range(0, 99);
        r = 1'b0;
        v = 1'b0;
        d = $urandom;
        if (k < 50) begin
          v = 1'($urandom_range(0, 1));
        end else if (k < 65) begin
          d = frm(10, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), 16'hBEEF);
          v = 1'b1;
        end else if (k < 75) begin
          d = frm(10, $urandom_range(0, 15), m_id, m_id + 1, 16'hBEEF);
          v = 1'b1;
        end else if (k < 75 + ack_pct) begin
          d = frm(10, $urandom_range(0, 15), m_id + 1, m_id + 2,
                  ($urandom_range(0, 3) == 0) ? 16'hDEAD : 16'hBEEF);
          v = 1'($urandom_range(0, 3) != 0);
        end else if (k == 99 && $urandom_range(0, 3) == 0) begin
          r = 1'b1;
        end
        cyc(r, ($urandom_range(0, 9) == 0) ? ~fl : fl, d, v);
        if (m_phase == 3) done_cnt++;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
